// File: rtl/operand_sel_stage.sv
// Operand-select pipeline stage: forwards writeback data onto the source operands,
// picks ALU operands per opcode and registers them behind a single-entry valid/ready slot.
module operand_sel_stage #(
    parameter int DATA_W = 32,
    parameter int OPC_W  = 6,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    input  logic [DATA_W-1:0] reg_rs1,
    input  logic [DATA_W-1:0] reg_rs2,
    input  logic [DATA_W-1:0] imm,
    input  logic              fwd_valid,
    input  logic [REG_AW-1:0] fwd_addr,
    input  logic [DATA_W-1:0] fwd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [OPC_W-1:0]  out_opcode,
    output logic              illegal,
    output logic [CNT_W-1:0]  illegal_cnt
);

    localparam logic [OPC_W-1:0] OP_ADD   = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_SUB   = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_STORE = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_LOAD  = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_MOVE  = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_SGE   = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_SLE   = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_SGT   = OPC_W'(8);
    localparam logic [OPC_W-1:0] OP_SLT   = OPC_W'(9);
    localparam logic [OPC_W-1:0] OP_SEQ   = OPC_W'(10);
    localparam logic [OPC_W-1:0] OP_SNE   = OPC_W'(11);
    localparam logic [OPC_W-1:0] OP_AND   = OPC_W'(12);
    localparam logic [OPC_W-1:0] OP_OR    = OPC_W'(13);
    localparam logic [OPC_W-1:0] OP_XOR   = OPC_W'(14);
    localparam logic [OPC_W-1:0] OP_NOT   = OPC_W'(15);
    localparam logic [OPC_W-1:0] OP_MOVEI = OPC_W'(16);
    localparam logic [OPC_W-1:0] OP_SLI   = OPC_W'(17);
    localparam logic [OPC_W-1:0] OP_SRI   = OPC_W'(18);
    localparam logic [OPC_W-1:0] OP_ADDI  = OPC_W'(19);
    localparam logic [OPC_W-1:0] OP_SUBI  = OPC_W'(20);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [DATA_W-1:0] a_next;
    logic [DATA_W-1:0] b_next;
    logic              ill_next;
    logic              accept;

    // Handshake: a beat moves when valid && ready on the same rising edge; in_ready
    // depends only on the output slot so a full slot can drain and refill each cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Register 0 is hard-wired zero, so it is never a forwarding target.
    assign src1 = (fwd_valid && (fwd_addr == rs1_addr) && (rs1_addr != '0)) ? fwd_data : reg_rs1;
    assign src2 = (fwd_valid && (fwd_addr == rs2_addr) && (rs2_addr != '0)) ? fwd_data : reg_rs2;

    always_comb begin
        a_next   = '0;
        b_next   = '0;
        ill_next = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_SGE, OP_SLE, OP_SGT, OP_SLT, OP_SEQ, OP_SNE,
            OP_AND, OP_OR, OP_XOR: begin
                a_next = src1;
                b_next = src2;
            end
            OP_LOAD, OP_SLI, OP_SRI, OP_ADDI, OP_SUBI: begin
                a_next = src1;
                b_next = imm;
            end
            OP_STORE: begin
                a_next = src2;
                b_next = imm;
            end
            OP_MOVE, OP_NOT: a_next = src1;
            OP_MOVEI:        a_next = imm;
            default:         ill_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            out_opcode <= '0;
            illegal    <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            op_a       <= a_next;
            op_b       <= b_next;
            out_opcode <= opcode;
            illegal    <= ill_next;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_cnt <= '0;
        end else if (accept && ill_next && (illegal_cnt != CNT_MAX)) begin
            illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_operand_sel_stage.sv
// Directed bench for operand_sel_stage: opcode/forwarding table, backpressure,
// illegal-counter saturation and asynchronous reset sequences.
module tb_operand_sel_stage;

    localparam int DATA_W = 32;
    localparam int OPC_W  = 6;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 8;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [OPC_W-1:0]  opcode;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [DATA_W-1:0] reg_rs1;
    logic [DATA_W-1:0] reg_rs2;
    logic [DATA_W-1:0] imm;
    logic              fwd_valid;
    logic [REG_AW-1:0] fwd_addr;
    logic [DATA_W-1:0] fwd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [OPC_W-1:0]  out_opcode;
    logic              illegal;
    logic [CNT_W-1:0]  illegal_cnt;

    operand_sel_stage #(
        .DATA_W(DATA_W), .OPC_W(OPC_W), .REG_AW(REG_AW), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .reg_rs1(reg_rs1), .reg_rs2(reg_rs2), .imm(imm),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready), .op_a(op_a), .op_b(op_b),
        .out_opcode(out_opcode), .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [OPC_W-1:0]  opc;
        logic [REG_AW-1:0] a1;
        logic [REG_AW-1:0] a2;
        logic [DATA_W-1:0] r1;
        logic [DATA_W-1:0] r2;
        logic [DATA_W-1:0] im;
        logic              fv;
        logic [REG_AW-1:0] fa;
        logic [DATA_W-1:0] fd;
        logic [DATA_W-1:0] ea;
        logic [DATA_W-1:0] eb;
        logic              eill;
    } vec_t;

    vec_t              tbl[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] cur_exp_a;
    logic [CNT_W-1:0]  exp_cnt;
    int                checks;
    int                errors;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic [OPC_W-1:0] opc, input logic [REG_AW-1:0] a1,
                           input logic [REG_AW-1:0] a2, input logic [DATA_W-1:0] r1,
                           input logic [DATA_W-1:0] r2, input logic [DATA_W-1:0] im,
                           input logic fv, input logic [REG_AW-1:0] fa,
                           input logic [DATA_W-1:0] fd, input logic [DATA_W-1:0] ea,
                           input logic [DATA_W-1:0] eb, input logic eill);
        vec_t v;
        v.opc = opc; v.a1 = a1; v.a2 = a2; v.r1 = r1; v.r2 = r2; v.im = im;
        v.fv = fv; v.fa = fa; v.fd = fd; v.ea = ea; v.eb = eb; v.eill = eill;
        tbl.push_back(v);
    endtask

    // driver
    task automatic drive_instr(input logic [OPC_W-1:0] opc, input logic [REG_AW-1:0] a1,
                               input logic [REG_AW-1:0] a2, input logic [DATA_W-1:0] r1,
                               input logic [DATA_W-1:0] r2, input logic [DATA_W-1:0] im,
                               input logic fv, input logic [REG_AW-1:0] fa,
                               input logic [DATA_W-1:0] fd, input logic [DATA_W-1:0] ea);
        in_valid = 1'b1;
        opcode = opc; rs1_addr = a1; rs2_addr = a2;
        reg_rs1 = r1; reg_rs2 = r2; imm = im;
        fwd_valid = fv; fwd_addr = fa; fwd_data = fd;
        cur_exp_a = ea;
    endtask

    // scoreboard: sampled mid-cycle, predicting the handshakes of the coming edge
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) check("sb_op_a", op_a, exp_q.pop_front());
            end
            if (in_valid && in_ready) exp_q.push_back(cur_exp_a);
        end
    end

    initial begin
        checks = 0; errors = 0; exp_cnt = '0; cur_exp_a = '0;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        opcode = '0; rs1_addr = '0; rs2_addr = '0; reg_rs1 = '0; reg_rs2 = '0;
        imm = '0; fwd_valid = 1'b0; fwd_addr = '0; fwd_data = '0;

        //       opc  rs1 rs2 reg_rs1     reg_rs2     imm         fv fa  fd          exp_a       exp_b       ill
        add_vec(6'd1,  3, 4, 32'h10,     32'h20,     32'h5,      0, 0, 32'h0,       32'h10,     32'h20,     0);
        add_vec(6'd3,  1, 2, 32'h11,     32'hAA,     32'h8,      0, 0, 32'h0,       32'hAA,     32'h8,      0);
        add_vec(6'd19, 1, 2, 32'h5,      32'h33,     32'h7,      0, 0, 32'h0,       32'h5,      32'h7,      0);
        add_vec(6'd1,  3, 4, 32'h10,     32'h20,     32'h0,      1, 3, 32'h99,      32'h99,     32'h20,     0);
        add_vec(6'd1,  0, 4, 32'h10,     32'h20,     32'h0,      1, 0, 32'h99,      32'h10,     32'h20,     0);
        add_vec(6'd2,  5, 6, 32'h1,      32'h2,      32'h0,      1, 6, 32'h77,      32'h1,      32'h77,     0);
        add_vec(6'd4,  1, 2, 32'h40,     32'h41,     32'h4,      0, 0, 32'h0,       32'h40,     32'h4,      0);
        add_vec(6'd5,  1, 2, 32'h55,     32'h66,     32'h9,      0, 0, 32'h0,       32'h55,     32'h0,      0);
        add_vec(6'd15, 1, 2, 32'hF0,     32'h66,     32'h9,      0, 0, 32'h0,       32'hF0,     32'h0,      0);
        add_vec(6'd16, 1, 2, 32'h1,      32'h2,      32'h1234,   0, 0, 32'h0,       32'h1234,   32'h0,      0);
        add_vec(6'd9,  1, 2, 32'h3,      32'h4,      32'h9,      0, 0, 32'h0,       32'h3,      32'h4,      0);
        add_vec(6'd11, 1, 2, 32'h7,      32'h8,      32'h9,      0, 0, 32'h0,       32'h7,      32'h8,      0);
        add_vec(6'd14, 1, 2, 32'hA,      32'hB,      32'h9,      0, 0, 32'h0,       32'hA,      32'hB,      0);
        add_vec(6'd18, 1, 2, 32'h80,     32'h81,     32'h2,      0, 0, 32'h0,       32'h80,     32'h2,      0);
        add_vec(6'd20, 1, 2, 32'h9,      32'h81,     32'h1,      0, 0, 32'h0,       32'h9,      32'h1,      0);
        add_vec(6'd17, 1, 2, 32'hC,      32'hD,      32'h3,      0, 0, 32'h0,       32'hC,      32'h3,      0);
        add_vec(6'd0,  1, 2, 32'h5,      32'h6,      32'h7,      0, 0, 32'h0,       32'h0,      32'h0,      1);
        add_vec(6'd21, 1, 2, 32'h5,      32'h6,      32'h7,      0, 0, 32'h0,       32'h0,      32'h0,      1);
        add_vec(6'd3,  1, 7, 32'h11,     32'hAA,     32'h10,     1, 7, 32'hBEEF,    32'hBEEF,   32'h10,     0);
        add_vec(6'd6,  2, 2, 32'h1,      32'h1,      32'h0,      1, 2, 32'h5A,      32'h5A,     32'h5A,     0);

        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_op_a", op_a, 0);
        check("rst_op_b", op_b, 0);
        check("rst_opcode", out_opcode, 0);
        check("rst_illegal", illegal, 0);
        check("rst_cnt", illegal_cnt, 0);
        step();
        reset = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 1);

        foreach (tbl[i]) begin
            drive_instr(tbl[i].opc, tbl[i].a1, tbl[i].a2, tbl[i].r1, tbl[i].r2,
                        tbl[i].im, tbl[i].fv, tbl[i].fa, tbl[i].fd, tbl[i].ea);
            if (tbl[i].eill && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
            step();
            check($sformatf("vec%0d_valid", i), out_valid, 1);
            check($sformatf("vec%0d_op_a", i), op_a, tbl[i].ea);
            check($sformatf("vec%0d_op_b", i), op_b, tbl[i].eb);
            check($sformatf("vec%0d_opcode", i), out_opcode, tbl[i].opc);
            check($sformatf("vec%0d_illegal", i), illegal, tbl[i].eill);
            check($sformatf("vec%0d_cnt", i), illegal_cnt, exp_cnt);
        end

        // backpressure: held operands ignore new inputs and later forwarding changes
        drive_instr(6'd1, 3, 4, 32'h100, 32'h1, 32'h0, 1, 3, 32'h300, 32'h300);
        step();
        check("bp_first_op_a", op_a, 32'h300);
        drive_instr(6'd1, 4, 5, 32'h200, 32'h2, 32'h0, 1, 3, 32'h999, 32'h200);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            fwd_data = 32'h777 + DATA_W'(k);
            #1;
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_op_a", op_a, 32'h300);
            check("bp_hold_op_b", op_b, 32'h1);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        step();
        check("bp_next_valid", out_valid, 1);
        check("bp_next_op_a", op_a, 32'h200);
        in_valid = 1'b0;
        step();
        check("bp_drain_valid", out_valid, 0);
        check("bp_drain_op_a", op_a, 32'h200);
        check("bp_drained", exp_q.size(), 0);

        // illegal opcode flood saturates the counter
        for (int k = 0; k < 300; k++) begin
            drive_instr(6'h3F, 1, 2, 32'h5, 32'h6, 32'h7, 0, 0, 32'h0, 32'h0);
            if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
            step();
            check("ill_op_a", op_a, 0);
            check("ill_op_b", op_b, 0);
            check("ill_flag", illegal, 1);
            check("ill_cnt", illegal_cnt, exp_cnt);
        end
        check("ill_cnt_sat", illegal_cnt, 8'hFF);

        // asynchronous reset between edges while holding a valid beat
        check("pre_rst_valid", out_valid, 1);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_cnt", illegal_cnt, 0);
        check("async_rst_op_a", op_a, 0);
        check("async_rst_illegal", illegal, 0);
        exp_q.delete();
        exp_cnt = '0;
        #1;
        reset = 1'b0;
        #1;
        check("post_rst_ready", in_ready, 1);
        drive_instr(6'd1, 1, 2, 32'h42, 32'h24, 32'h0, 0, 0, 32'h0, 32'h42);
        step();
        check("post_rst_valid", out_valid, 1);
        check("post_rst_op_a", op_a, 32'h42);
        check("post_rst_op_b", op_b, 32'h24);
        check("post_rst_cnt", illegal_cnt, 0);
        in_valid = 1'b0;
        step();
        check("post_rst_drain", out_valid, 0);
        check("final_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_sel_stage.md
OPERAND_SEL_STAGE -- requirements
Module: operand_sel_stage

Interface
REQ-001 Parameter DATA_W, default 32: operand and immediate width.
REQ-002 Parameter OPC_W, default 6: opcode width.
REQ-003 Parameter REG_AW, default 5: register-address width; address 0 is the hard-wired zero register.
REQ-004 Parameter CNT_W, default 8: illegal-opcode counter width.
REQ-005 Ports, in order (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream has a decoded instruction.
- in_ready  out  1  stage can accept this cycle.
- opcode  in  OPC_W  instruction opcode.
- rs1_addr, rs2_addr  in  REG_AW  source register addresses.
- reg_rs1, reg_rs2  in  DATA_W  register-file read data.
- imm  in  DATA_W  immediate, already extended.
- fwd_valid  in  1  a writeback is in flight.
- fwd_addr  in  REG_AW  writeback destination.
- fwd_data  in  DATA_W  writeback value.
- out_valid  out  1  registered operands are valid.
- out_ready  in  1  downstream accepts.
- op_a, op_b  out  DATA_W  registered ALU operands.
- out_opcode  out  OPC_W  registered opcode.
- illegal  out  1  registered flag: the held opcode is unsupported.
- illegal_cnt  out  CNT_W  saturating count of accepted illegal opcodes.

Function
REQ-006 Opcode encoding: ADD=1, SUB=2, STORE=3, LOAD=4, MOVE=5, SGE=6, SLE=7, SGT=8, SLT=9, SEQ=10, SNE=11, AND=12, OR=13, XOR=14, NOT=15, MOVEI=16, SLI=17, SRI=18, ADDI=19, SUBI=20; every other value is illegal.
REQ-007 Forwarded sources: src1 = fwd_data when fwd_valid, fwd_addr==rs1_addr and rs1_addr!=0; otherwise src1 = reg_rs1. src2 is formed the same way from rs2_addr and reg_rs2.
REQ-008 op_a selection: src1 for ADD, SUB, LOAD, MOVE, SGE–SLT, SEQ, SNE, AND, OR, XOR, NOT, SLI, SRI, ADDI and SUBI; src2 for STORE; imm for MOVEI; 0 for illegal opcodes.
REQ-009 op_b selection: src2 for ADD, SUB, SGE–SNE, AND, OR and XOR; imm for LOAD, STORE, SLI, SRI, ADDI and SUBI; 0 for MOVE, NOT, MOVEI and illegal opcodes.
REQ-010 The stage is a single registered stage with a valid/ready handshake: in_ready = !out_valid || out_ready (combinational).
REQ-011 Accept occurs when in_valid && in_ready. On accept, op_a, op_b, out_opcode and illegal load at the next rising edge, and out_valid becomes 1. Latency is 1 cycle.
REQ-012 If out_valid && out_ready and there is no accept, out_valid becomes 0 at the next edge; the data registers hold their values.
REQ-013 If out_valid && !out_ready, all output registers hold stable, in_ready is 0, and the inputs are ignored.
REQ-014 If a transfer out and an accept occur in the same cycle, the new data loads and out_valid stays 1, giving full throughput with no bubble.
REQ-015 illegal_cnt increments by 1 on each accept of an illegal opcode and saturates at 2^CNT_W-1 (no wrap).
REQ-016 Forwarding is sampled only in the accept cycle; a later change to fwd_* does not alter held operands.
REQ-017 A fwd_addr of 0 never forwards, even with fwd_valid=1.

Reset
REQ-018 While reset=1, out_valid, op_a, op_b, out_opcode, illegal and illegal_cnt are 0, asynchronously and regardless of clk.
REQ-019 Reset asserted mid-transfer discards the held instruction; after deassertion, in_ready is 1 and the first accept behaves as in REQ-011.

Verification
REQ-020 ADD, rs1=3, rs2=4, reg_rs1=0x10, reg_rs2=0x20, out_ready=1 -> next cycle out_valid=1, op_a=0x10, op_b=0x20, illegal=0.
REQ-021 STORE, reg_rs2=0xAA, imm=0x8 -> op_a=0xAA, op_b=0x8. ADDI, reg_rs1=5, imm=7 -> op_a=5, op_b=7.
REQ-022 ADD, rs1=3, fwd_valid=1, fwd_addr=3, fwd_data=0x99 -> op_a=0x99. Same with rs1=0 and fwd_addr=0 -> op_a=reg_rs1.
REQ-023 out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0. Then out_ready=1 -> the next instruction appears one cycle later, with no loss and no duplicate.
REQ-024 Opcode 0x3F accepted 300 times with CNT_W=8 -> each accept gives op_a=op_b=0 and illegal=1, and illegal_cnt ends at 255.
REQ-025 Reset pulsed between edges while out_valid=1 -> out_valid=0 and illegal_cnt=0 immediately, without waiting for a clock edge.
